// File: rtl/hd63701_intctl.sv
// HD63701 interrupt arbiter/sequencer: prioritises NMI and maskable sources at
// instruction boundaries, hands one vector to the microcode and tracks ACK/DONE.
//
// state | meaning
// RSTV  | post-reset vector request outstanding
// IDLE  | no request; arbitrate when BOUND
// PEND  | request presented, vector frozen, waiting for ACK
// SVC   | stacking/vector fetch in progress, waiting for DONE
module hd63701_intctl #(
    parameter bit         NMI_SYNC = 1'b1,
    parameter logic [7:0] RST_VEC  = 8'hFE
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       NMI,
    input  logic       IRQ1,
    input  logic       ICF,
    input  logic       OCF,
    input  logic       TOF,
    input  logic       CMF,
    input  logic       IRQ2,
    input  logic       SCI,
    input  logic       INTE,
    input  logic       BOUND,
    input  logic       SLEEP,
    input  logic       ACK,
    input  logic       DONE,
    output logic       REQ,
    output logic [7:0] VECT,
    output logic       NMI_PEND,
    output logic       WAKE,
    output logic       BUSY
);

    typedef enum logic [1:0] {ST_RSTV, ST_IDLE, ST_PEND, ST_SVC} state_t;

    state_t     state, state_nxt;
    logic       req_q, busy_q, wake_q, nmi_latch, nmi_prev, raw_prev;
    logic [7:0] vect_q;
    logic [6:0] src_sel;
    logic       nmi_in, nmi_edge, nmi_clr, grant, any_qual, raw_any;
    logic [6:0] raw_lvl, mreq, win_sel;
    logic [7:0] win_vect;

    generate
        if (NMI_SYNC) begin : g_sync
            logic nmi_s1, nmi_s2;
            always_ff @(posedge CLK) begin
                if (RST) begin
                    nmi_s1 <= 1'b0;
                    nmi_s2 <= 1'b0;
                end else begin
                    nmi_s1 <= NMI;
                    nmi_s2 <= nmi_s1;
                end
            end
            assign nmi_in = nmi_s2;
        end else begin : g_nosync
            assign nmi_in = NMI;
        end
    endgenerate

    assign nmi_edge = nmi_in & ~nmi_prev;
    // bit 0 is the highest-priority maskable source
    assign raw_lvl  = {SCI, IRQ2, CMF, TOF, OCF, ICF, IRQ1};
    assign mreq     = raw_lvl & {7{INTE}};
    assign any_qual = nmi_latch | (|mreq);
    assign raw_any  = nmi_latch | (|raw_lvl);

    always_comb begin
        win_vect = 8'hF0;
        win_sel  = 7'b0;
        if (nmi_latch) begin
            win_vect = 8'hFC;
            win_sel  = 7'b0;
        end else if (mreq[0]) begin
            win_vect = 8'hF8;
            win_sel  = 7'b000_0001;
        end else if (mreq[1]) begin
            win_vect = 8'hF6;
            win_sel  = 7'b000_0010;
        end else if (mreq[2]) begin
            win_vect = 8'hF4;
            win_sel  = 7'b000_0100;
        end else if (mreq[3]) begin
            win_vect = 8'hF2;
            win_sel  = 7'b000_1000;
        end else if (mreq[4]) begin
            win_vect = 8'hEC;
            win_sel  = 7'b001_0000;
        end else if (mreq[5]) begin
            win_vect = 8'hEA;
            win_sel  = 7'b010_0000;
        end else if (mreq[6]) begin
            win_vect = 8'hF0;
            win_sel  = 7'b100_0000;
        end
    end

    always_comb begin
        state_nxt = state;
        nmi_clr   = 1'b0;
        grant     = 1'b0;
        case (state)
            ST_RSTV: begin
                if (ACK) state_nxt = ST_SVC;
            end
            ST_IDLE: begin
                if (BOUND && any_qual) begin
                    state_nxt = ST_PEND;
                    grant     = 1'b1;
                end
            end
            ST_PEND: begin
                // ACK beats withdrawal; an NMI grant has src_sel == 0 and never withdraws
                if (ACK) begin
                    state_nxt = ST_SVC;
                    nmi_clr   = (vect_q == 8'hFC);
                end else if ((|src_sel) && (!INTE || !(|(src_sel & raw_lvl)))) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_SVC: begin
                if (DONE) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_RSTV;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_RSTV;
            req_q     <= 1'b1;
            busy_q    <= 1'b1;
            wake_q    <= 1'b0;
            vect_q    <= RST_VEC;
            src_sel   <= 7'b0;
            nmi_latch <= 1'b0;
            nmi_prev  <= 1'b0;
            raw_prev  <= 1'b0;
        end else begin
            state     <= state_nxt;
            req_q     <= (state_nxt == ST_RSTV) || (state_nxt == ST_PEND);
            busy_q    <= (state_nxt != ST_IDLE);
            wake_q    <= SLEEP & raw_any & ~raw_prev;
            nmi_latch <= nmi_edge | (nmi_latch & ~nmi_clr);
            nmi_prev  <= nmi_in;
            raw_prev  <= raw_any;
            if (grant) begin
                vect_q  <= win_vect;
                src_sel <= win_sel;
            end
        end
    end

    assign REQ      = req_q;
    assign VECT     = vect_q;
    assign NMI_PEND = nmi_latch;
    assign WAKE     = wake_q;
    assign BUSY     = busy_q;

endmodule

// File: tb/tb_hd63701_intctl.sv
// Scoreboard bench for hd63701_intctl: snapshot expectations keyed by cycle and
// a vector queue checked whenever REQ rises.
module tb_hd63701_intctl;

    logic       CLK = 1'b0, RST = 1'b1, NMI = 1'b0, INTE = 1'b0, BOUND = 1'b0;
    logic       SLEEP = 1'b0, ACK = 1'b0, DONE = 1'b0;
    logic [6:0] src = '0;   // IRQ1, ICF, OCF, TOF, CMF, IRQ2, SCI from bit 0 up
    logic       REQ, NMI_PEND, WAKE, BUSY;
    logic [7:0] VECT;

    hd63701_intctl dut (
        .CLK(CLK), .RST(RST), .NMI(NMI),
        .IRQ1(src[0]), .ICF(src[1]), .OCF(src[2]), .TOF(src[3]),
        .CMF(src[4]), .IRQ2(src[5]), .SCI(src[6]),
        .INTE(INTE), .BOUND(BOUND), .SLEEP(SLEEP), .ACK(ACK), .DONE(DONE),
        .REQ(REQ), .VECT(VECT), .NMI_PEND(NMI_PEND), .WAKE(WAKE), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic       req;
        logic [7:0] vect;
        logic       npend;
        logic       wake;
        logic       busy;
    } snap_t;

    snap_t      exp_q[$];
    string      name_q[$];
    logic [7:0] vec_q[$];
    int         n_pass = 0, n_total = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        else n_pass++;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic snap(input string nm, input logic req, input logic [7:0] vect,
                        input logic npend, input logic wake, input logic busy);
        snap_t s;
        s.cyc = cyc; s.req = req; s.vect = vect; s.npend = npend; s.wake = wake; s.busy = busy;
        exp_q.push_back(s);
        name_q.push_back(nm);
    endtask

    snap_t sm;
    string snm;
    always @(negedge CLK) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            sm  = exp_q.pop_front();
            snm = name_q.pop_front();
            chk({snm, ".req"},   32'(REQ),      32'(sm.req));
            chk({snm, ".vect"},  32'(VECT),     32'(sm.vect));
            chk({snm, ".npend"}, 32'(NMI_PEND), 32'(sm.npend));
            chk({snm, ".wake"},  32'(WAKE),     32'(sm.wake));
            chk({snm, ".busy"},  32'(BUSY),     32'(sm.busy));
        end
    end

    logic req_prev = 1'b0;
    always @(negedge CLK) begin
        if (REQ === 1'b1 && req_prev !== 1'b1) begin
            if (vec_q.size() == 0) begin
                n_total++;
                $display("FAIL req_unexpected: REQ rose with VECT=%0h, required no request", VECT);
            end else begin
                chk("req_vect", 32'(VECT), 32'(vec_q.pop_front()));
            end
        end
        req_prev <= REQ;
    end

    logic [7:0] ptab [7] = '{8'hF8, 8'hF6, 8'hF4, 8'hF2, 8'hEC, 8'hEA, 8'hF0};

    initial begin
        int k;
        vec_q.push_back(8'hFE);
        RST = 1'b1;
        step(2);
        snap("reset", 1, 8'hFE, 0, 0, 1);
        RST = 1'b0;
        step(3);
        snap("rstv_hold", 1, 8'hFE, 0, 0, 1);
        ACK = 1'b1; step(1); ACK = 1'b0;
        snap("rstv_ack", 0, 8'hFE, 0, 0, 1);
        step(2);
        snap("rstv_svc", 0, 8'hFE, 0, 0, 1);
        DONE = 1'b1; step(1); DONE = 1'b0;
        snap("rstv_done", 0, 8'hFE, 0, 0, 0);

        // IRQ1 beats TOF, then TOF follows once IRQ1 drops
        INTE = 1'b1; BOUND = 1'b1; src = 7'b000_1001;
        vec_q.push_back(8'hF8);
        step(1); snap("irq1_pend", 1, 8'hF8, 0, 0, 1);
        ACK = 1'b1; step(1); ACK = 1'b0;
        snap("irq1_svc", 0, 8'hF8, 0, 0, 1);
        DONE = 1'b1; src[0] = 1'b0; step(1); DONE = 1'b0;
        snap("irq1_done", 0, 8'hF8, 0, 0, 0);
        vec_q.push_back(8'hF2);
        step(1); snap("tof_pend", 1, 8'hF2, 0, 0, 1);
        ACK = 1'b1; step(1); ACK = 1'b0;
        snap("tof_svc", 0, 8'hF2, 0, 0, 1);
        DONE = 1'b1; src = '0; step(1); DONE = 1'b0;
        step(1); snap("tof_idle", 0, 8'hF2, 0, 0, 0);

        for (int i = 0; i < 7; i++) begin
            src = 7'h7F << i;
            vec_q.push_back(ptab[i]);
            step(1); snap($sformatf("prio%0d_pend", i), 1, ptab[i], 0, 0, 1);
            ACK = 1'b1; src = '0; step(1); ACK = 1'b0;
            snap($sformatf("prio%0d_svc", i), 0, ptab[i], 0, 0, 1);
            DONE = 1'b1; step(1); DONE = 1'b0;
            step(1); snap($sformatf("prio%0d_idle", i), 0, ptab[i], 0, 0, 0);
        end

        // masked OCF is ignored; NMI is not maskable and is never withdrawn
        INTE = 1'b0; src[2] = 1'b1;
        step(2); snap("masked_ocf", 0, 8'hF0, 0, 0, 0);
        NMI = 1'b1;
        vec_q.push_back(8'hFC);
        k = 0;
        while (REQ !== 1'b1 && k < 10) begin
            step(1);
            k++;
        end
        chk("nmi_req_seen", 32'(REQ), 32'd1);
        snap("nmi_pend", 1, 8'hFC, 1, 0, 1);
        NMI = 1'b0;
        step(3); snap("nmi_no_withdraw", 1, 8'hFC, 1, 0, 1);
        ACK = 1'b1; step(1); ACK = 1'b0;
        snap("nmi_ack", 0, 8'hFC, 0, 0, 1);
        DONE = 1'b1; step(1); DONE = 1'b0;
        snap("nmi_done", 0, 8'hFC, 0, 0, 0);
        step(1); snap("nmi_idle", 0, 8'hFC, 0, 0, 0);
        src = '0;

        // withdrawal by source drop, ACK winning over a drop, withdrawal by INTE drop
        INTE = 1'b1; src[5] = 1'b1;
        vec_q.push_back(8'hEA);
        step(1); snap("irq2_pend", 1, 8'hEA, 0, 0, 1);
        src[5] = 1'b0;
        step(1); snap("irq2_withdraw", 0, 8'hEA, 0, 0, 0);
        src[5] = 1'b1;
        vec_q.push_back(8'hEA);
        step(1); snap("irq2_pend2", 1, 8'hEA, 0, 0, 1);
        src[5] = 1'b0; ACK = 1'b1; step(1); ACK = 1'b0;
        snap("irq2_ack_wins", 0, 8'hEA, 0, 0, 1);
        DONE = 1'b1; step(1); DONE = 1'b0;
        snap("irq2_done", 0, 8'hEA, 0, 0, 0);
        src[0] = 1'b1;
        vec_q.push_back(8'hF8);
        step(1); snap("inte_pend", 1, 8'hF8, 0, 0, 1);
        INTE = 1'b0;
        step(1); snap("inte_withdraw", 0, 8'hF8, 0, 0, 0);
        src = '0; INTE = 1'b1;
        step(1); snap("inte_idle", 0, 8'hF8, 0, 0, 0);

        // NMI edge during SCI service; ACK in SVC is ignored
        src[6] = 1'b1;
        vec_q.push_back(8'hF0);
        step(1); snap("sci_pend", 1, 8'hF0, 0, 0, 1);
        ACK = 1'b1; step(1); ACK = 1'b0; src = '0;
        snap("sci_svc", 0, 8'hF0, 0, 0, 1);
        NMI = 1'b1;
        step(4); snap("nmi_in_svc", 0, 8'hF0, 1, 0, 1);
        ACK = 1'b1; step(1); ACK = 1'b0;
        snap("svc_ack_ignored", 0, 8'hF0, 1, 0, 1);
        vec_q.push_back(8'hFC);
        DONE = 1'b1; step(1); DONE = 1'b0;
        snap("sci_done", 0, 8'hF0, 1, 0, 0);
        step(1); snap("nmi_after_svc", 1, 8'hFC, 1, 0, 1);
        ACK = 1'b1; step(1); ACK = 1'b0; NMI = 1'b0;
        snap("nmi2_ack", 0, 8'hFC, 0, 0, 1);
        DONE = 1'b1; step(1); DONE = 1'b0;
        snap("nmi2_done", 0, 8'hFC, 0, 0, 0);

        // wake from SLP on a masked source rise
        INTE = 1'b0; SLEEP = 1'b1;
        step(2); snap("sleep_quiet", 0, 8'hFC, 0, 0, 0);
        src[4] = 1'b1;
        step(1); snap("wake_pulse", 0, 8'hFC, 0, 1, 0);
        step(1); snap("wake_once", 0, 8'hFC, 0, 0, 0);
        step(2); snap("wake_held_src", 0, 8'hFC, 0, 0, 0);

        // reset while pending
        SLEEP = 1'b0; src = 7'b000_0010; INTE = 1'b1;
        vec_q.push_back(8'hF6);
        step(1); snap("icf_pend", 1, 8'hF6, 0, 0, 1);
        RST = 1'b1; step(1);
        snap("rst_in_pend", 1, 8'hFE, 0, 0, 1);
        RST = 1'b0; src = '0;
        step(1); snap("rstv_again", 1, 8'hFE, 0, 0, 1);
        ACK = 1'b1; step(1); ACK = 1'b0;
        snap("rstv2_ack", 0, 8'hFE, 0, 0, 1);
        DONE = 1'b1; step(1); DONE = 1'b0;
        snap("rstv2_done", 0, 8'hFE, 0, 0, 0);

        step(2);
        chk("snap_q_drained", 32'(exp_q.size()), 32'd0);
        chk("vec_q_drained", 32'(vec_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

endmodule
